audio_status_input: RTL and testbench

Avalon-MM slave input port with edge capture and interrupt, the read-side companion of the audio control output port. It samples status lines from the audio codec path, such as the ADC-ready and DAC-underrun flags, into the processor's address space. It latches edges per bit and raises a level interrupt to the Nios II. It sits on the Qsys interconnect beside the audio control port.

---
 rtl/audio_status_input.sv | 115 +++++++++++
 tb/tb_audio_status_input.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_status_input.sv
// Avalon-MM status input port: synchronizes status lines, captures edges per bit, raises a level irq.
// Build option AUDIO_STATUS_INPUT_SYNC_EN selects the 2-flop synchronizer; otherwise inputs are registered once.
module audio_status_input #(
    parameter int WIDTH     = 2,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic [1:0]       arm_cnt;
    logic             armed;
    logic             wr_mask;
    logic             wr_edge;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

`ifdef AUDIO_STATUS_INPUT_SYNC_EN
    localparam logic [1:0] ARM_MAX = 2'd3;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    assign samp = s2;
`else
    localparam logic [1:0] ARM_MAX = 2'd2;
    logic [WIDTH-1:0] samp_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_q <= '0;
        end else begin
            samp_q <= in_port;
        end
    end

    assign samp = samp_q;
`endif

    // Arming holds off detection until prev has seen the first real sample, so
    // levels already present at reset release are not mistaken for edges.
    assign armed = (arm_cnt == ARM_MAX);

    always_comb begin
        edge_raw = samp ^ prev;
        case (EDGE_TYPE)
            0:       edge_raw = samp & ~prev;
            1:       edge_raw = ~samp & prev;
            default: edge_raw = samp ^ prev;
        endcase
    end

    assign det     = armed ? edge_raw : '0;
    assign wr_mask = chipselect && !write_n && (address == 2'd2);
    assign wr_edge = chipselect && !write_n && (address == 2'd3);
    assign clr     = wr_edge ? writedata[WIDTH-1:0] : '0;
    assign irq     = |(edgecap & irqmask);

    assign unused_wdata = ^writedata;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = 32'(samp);
            2'd2:    rd_mux = 32'(irqmask);
            2'd3:    rd_mux = 32'(edgecap);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            arm_cnt  <= '0;
            edgecap  <= '0;
            irqmask  <= '0;
            readdata <= '0;
        end else begin
            prev <= samp;
            if (arm_cnt != ARM_MAX) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            // Set after clear: a detection coinciding with a W1C write survives.
            edgecap <= (edgecap & ~clr) | det;
            if (wr_mask) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_audio_status_input.sv
// Directed self-checking bench for audio_status_input (rising-edge and any-edge instances).
// Latencies follow AUDIO_STATUS_INPUT_SYNC_EN the same way the design does.
module tb_audio_status_input;

`ifdef AUDIO_STATUS_INPUT_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 1;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [1:0]  in0;
    logic [1:0]  in2;
    logic [31:0] rd0;
    logic [31:0] rd2;
    logic        irq0;
    logic        irq2;

    int n_checks;
    int n_fail;

    audio_status_input #(.WIDTH(2), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0)
    );

    audio_status_input #(.WIDTH(2), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(rd2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        in0 = 2'b11;
        in2 = 2'b00;
        tick(3);
        n_checks++;
        if (rd0 !== 32'd0 || irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: readdata=%h irq=%b required 0/0", rd0, irq0);
        end
        reset_n = 1'b1;
        tick(6);
        bus_read(2'd0);
        n_checks++;
        if (rd0 !== 32'd3) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 00000003", rd0);
        end
        bus_read(2'd3);
        n_checks++;
        if (rd0 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_no_capture: edgecap %h required 0", rd0);
        end
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b required 0", irq0);
        end
    endtask

    task automatic test_data;
        address = 2'd0;
        in0 = 2'b10;
        tick(SYNC);
        n_checks++;
        if (rd0 !== 32'd3) begin
            n_fail++;
            $display("FAIL data_early: got %h required 00000003", rd0);
        end
        tick();
        n_checks++;
        if (rd0 !== 32'd2) begin
            n_fail++;
            $display("FAIL data_latency: got %h required 00000002", rd0);
        end
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1);
        n_checks++;
        if (rd0 !== 32'd0) begin
            n_fail++;
            $display("FAIL reserved_read: got %h required 0", rd0);
        end
        bus_read(2'd0);
        n_checks++;
        if (rd0 !== 32'd2) begin
            n_fail++;
            $display("FAIL data_write_ignored: got %h required 00000002", rd0);
        end
    endtask

    task automatic test_rise_irq;
        bus_write(2'd2, 32'h1);
        in0 = 2'b00;
        tick(4);
        bus_read(2'd3);
        n_checks++;
        if (rd0 !== 32'd0) begin
            n_fail++;
            $display("FAIL fall_ignored: edgecap %h required 0", rd0);
        end
        in0 = 2'b01;
        tick(SYNC);
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_early: got %b required 0", irq0);
        end
        tick();
        n_checks++;
        if (irq0 !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_on_capture: got %b required 1", irq0);
        end
        bus_read(2'd3);
        n_checks++;
        if (rd0 !== 32'd1) begin
            n_fail++;
            $display("FAIL edgecap_bit0: got %h required 00000001", rd0);
        end
        bus_write(2'd3, 32'h1);
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_irq: got %b required 0", irq0);
        end
        bus_read(2'd3);
        n_checks++;
        if (rd0 !== 32'd0) begin
            n_fail++;
            $display("FAIL w1c_clear: edgecap %h required 0", rd0);
        end
    endtask

    task automatic test_mask;
        in0 = 2'b11;
        tick(SYNC + 3);
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_out_irq: got %b required 0", irq0);
        end
        bus_read(2'd3);
        n_checks++;
        if (rd0 !== 32'd2) begin
            n_fail++;
            $display("FAIL edgecap_bit1: got %h required 00000002", rd0);
        end
        bus_write(2'd2, 32'h3);
        n_checks++;
        if (irq0 !== 1'b1) begin
            n_fail++;
            $display("FAIL unmask_irq: got %b required 1", irq0);
        end
        bus_read(2'd2);
        n_checks++;
        if (rd0 !== 32'd3) begin
            n_fail++;
            $display("FAIL mask_read: got %h required 00000003", rd0);
        end
        bus_write(2'd2, 32'h0);
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_off_irq: got %b required 0", irq0);
        end
        bus_read(2'd3);
        n_checks++;
        if (rd0 !== 32'd2) begin
            n_fail++;
            $display("FAIL edgecap_retained: got %h required 00000002", rd0);
        end
        bus_write(2'd3, 32'h2);
        bus_write(2'd2, 32'h3);
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL cleared_irq: got %b required 0", irq0);
        end
    endtask

    task automatic test_back_to_back;
        in0 = 2'b10;
        tick(4);
        in0 = 2'b11;
        tick(4);
        in0 = 2'b10;
        tick(4);
        in0 = 2'b11;
        tick(SYNC);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3);
        n_checks++;
        if (rd0 !== 32'd1) begin
            n_fail++;
            $display("FAIL clear_vs_detect: edgecap %h required 00000001", rd0);
        end
        n_checks++;
        if (irq0 !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_vs_detect_irq: got %b required 1", irq0);
        end
        bus_write(2'd3, 32'h3);
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL final_clear_irq: got %b required 0", irq0);
        end
    endtask

    task automatic test_any_edge;
        in2 = 2'b01;
        tick(4);
        bus_read(2'd3);
        n_checks++;
        if (rd2 !== 32'd1 || irq2 !== 1'b1) begin
            n_fail++;
            $display("FAIL any_rise: edgecap %h irq %b required 00000001/1", rd2, irq2);
        end
        bus_write(2'd3, 32'h1);
        in2 = 2'b00;
        tick(4);
        bus_read(2'd3);
        n_checks++;
        if (rd2 !== 32'd1 || irq2 !== 1'b1) begin
            n_fail++;
            $display("FAIL any_fall: edgecap %h irq %b required 00000001/1", rd2, irq2);
        end
        bus_read(2'd1);
        n_checks++;
        if (rd2 !== 32'd0) begin
            n_fail++;
            $display("FAIL any_reserved: got %h required 0", rd2);
        end
        bus_write(2'd3, 32'h3);
    endtask

    task automatic test_reset_mid;
        bus_write(2'd2, 32'h3);
        in0 = 2'b00;
        tick(4);
        in0 = 2'b11;
        tick(SYNC + 3);
        bus_read(2'd3);
        n_checks++;
        if (rd0 !== 32'd3 || irq0 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: edgecap %h irq %b required 00000003/1", rd0, irq0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (rd0 !== 32'd0 || irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: readdata %h irq %b required 0/0", rd0, irq0);
        end
        tick(2);
        reset_n = 1'b1;
        tick(6);
        bus_read(2'd3);
        n_checks++;
        if (rd0 !== 32'd0 || irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_capture: edgecap %h irq %b required 0/0", rd0, irq0);
        end
        bus_read(2'd2);
        n_checks++;
        if (rd0 !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_mask: got %h required 0", rd0);
        end
        bus_read(2'd0);
        n_checks++;
        if (rd0 !== 32'd3) begin
            n_fail++;
            $display("FAIL post_reset_data: got %h required 00000003", rd0);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        test_reset();
        test_data();
        test_rise_irq();
        test_mask();
        test_back_to_back();
        test_any_edge();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
